fp_div: RTL and testbench
=========================

// Module: fp_div
// PURPOSE
//  Iterative IEEE-754 single-precision divider, out = in1 / in2; inverse operation to fp_mul in the simple FPU.
//  Radix-2 restoring mantissa division, one quotient bit per clk; same 5 rounding modes and exception flags as fp_mul.
//  Started by act, completion signalled by done; sits beside fp_mul behind the FPU operation select.
// PARAMETERS
//  W  32   total word width
//  M  22   index of MSB of stored fraction (fraction = in[M:0])
//  E  30   index of MSB of exponent (exponent = in[E:M+1])
//  QW M+4  quotient bits generated (26: 1 integer + 25 fraction)
// PORTS
//  clk      in   1   clock
//  rst      in   1   reset, asynchronous, active-low
//  act      in   1   start request; sampled only in IDLE
//  in1      in   W   dividend
//  in2      in   W   divisor
//  round_m  in   3   rounding mode (`RNe, `RNa, `RZ, `RU, `RD)
//  out      out  W   quotient
//  ov,un    out  1   overflow / underflow
//  dz       out  1   divide by zero (finite nonzero / zero)
//  inv      out  1   invalid (0/0, inf/inf, sNaN operand)
//  inexact  out  1   rounded result differs from exact quotient
//  done     out  1   result valid; held until next act accepted
//  busy     out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: out=0, ov=un=dz=inv=inexact=done=busy=0, FSM=IDLE, datapath regs 0; reset mid-operation aborts, no result.
//  FSM: IDLE -act-> LOAD; LOAD -special-> FIN; LOAD -normal-> DIV; DIV (QW cycles, counter QW-1..0) -> RND -> FIN -> IDLE.
//  IDLE with act: latch in1,in2,round_m; clear done. act while busy is ignored; operands re-latched only in IDLE.
//  Latency act->done: special operands 2 cycles; normal operands QW+3 = 29 cycles. Outputs update only in FIN.
//  Exponent field 0 is treated as zero (denormals flushed). Sign S = S1^S2 on every result incl. inf/zero.
//  Special priority in LOAD: sNaN operand or 0/0 or inf/inf -> `FP_NANQ, inv=1; x/0 (x finite nonzero) -> ±inf, dz=1;
//   inf/x -> ±inf; 0/x or x/inf -> ±0; all other flags 0 for specials.
//  Mantissas: A={1,in1[M:0]}, B={1,in2[M:0]} (24b). Remainder R init A, width 25b; each DIV cycle:
//   D=R-B; if D>=0 {q=1,R=D} else q=0; R<<=1; Q={Q,q}. Q[QW-1] weight 2^0.
//  Exponent: 10-bit signed Ex = E1 - E2 + `B. Normalise: Q[QW-1]=1 -> man=Q[QW-1:2], g=Q[1], t=Q[0]|(R!=0);
//   else man=Q[QW-2:1], g=Q[0], t=(R!=0), Ex=Ex-1.
//  Rounding identical to fp_mul: RZ/RD/RU by sign select truncate vs increment on g|t; RNe increments on g&(t|lsb);
//   RNa increments on g. Increment carries from fraction into exponent ({Ex,frac}+1).
//  inexact = g|t. Final Ex>254 -> ±inf (0x7F800000|S), ov=1, inexact=1.
//  Final Ex<1 -> ±0, un=1, inexact=1. ov and un never both set.
//  done held high in FIN and IDLE until next accepted act; out/flags hold their value until next FIN.
// STRUCTURE
//  Shared include special_characters.v: `FP_INFP/`FP_INFN/`FP_ZEROP/`FP_ZERON/`FP_NANQ/`FP_NANS,
//   rounding-mode codes, bias `B; add FSM state encodings there (FPD_IDLE, FPD_LOAD, FPD_DIV, FPD_RND, FPD_FIN).
//  One sub-module: fp_div_mant — restoring shift-subtract core (start, A, B in; Q, rem_nz, mant_done out).
//  Top holds FSM, special-case decode, exponent path, rounding, output registers.
// TESTING
//  6.0/2.0: in1=0x40C00000 in2=0x40000000 RNe -> out=0x40400000, all flags 0, done 29 cycles after act.
//  1.0/3.0: in1=0x3F800000 in2=0x40400000 -> RNe out=0x3EAAAAAB, RZ out=0x3EAAAAAA, inexact=1.
//  1.0/0: in2=0x00000000 -> out=0x7F800000, dz=1, done 2 cycles after act; -1.0/0 -> 0xFF800000.
//  0/0 and inf/inf -> out=`FP_NANQ, inv=1, dz=0.
//  Overflow 0x7F000000/0x3E800000 -> out=0x7F800000, ov=1, inexact=1; underflow 0x00800000/0x7F000000 -> 0, un=1.
//  Pulse act at cycle 5 of a running divide -> ignored; assert rst at cycle 10 -> all outputs 0, next act restarts.

Source files
------------

// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared constants, rounding-mode codes and FSM states for the iterative FP divider
//   W/M/E/QW : word width, fraction MSB, exponent MSB, quotient bits generated
//   BIAS     : exponent bias
//   FP_*     : IEEE-754 single special encodings
//   RNE..RNA : rounding-mode codes carried on round_m
package fp_div_pkg;
  localparam int W = 32;
  localparam int M = 22;
  localparam int E = 30;
  localparam int QW = M + 4;
  localparam logic [9:0] BIAS = 10'd127;
  localparam logic [W-1:0] FP_INFP = 32'h7F80_0000;
  localparam logic [W-1:0] FP_INFN = 32'hFF80_0000;
  localparam logic [W-1:0] FP_ZEROP = 32'h0000_0000;
  localparam logic [W-1:0] FP_ZERON = 32'h8000_0000;
  localparam logic [W-1:0] FP_NANQ = 32'h7FC0_0000;
  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RZ = 3'd1;
  localparam logic [2:0] RD = 3'd2;
  localparam logic [2:0] RU = 3'd3;
  localparam logic [2:0] RNA = 3'd4;
  typedef enum logic [2:0] {FPD_IDLE, FPD_LOAD, FPD_DIV, FPD_RND, FPD_FIN} fpd_state_t;
endpackage

// File: rtl/fp_div_mant.sv
// fp_div_mant: radix-2 restoring mantissa divider, one quotient bit per clock
//   clk, rst       : clock, asynchronous active-low reset
//   start          : load a into the remainder and begin QW iterations
//   a, b           : 24-bit dividend / divisor mantissas (hidden bit set)
//   q              : QW-bit quotient, q[QW-1] has weight 2^0
//   rem_nz         : final remainder is nonzero (sticky source)
//   mant_done      : high during the last iteration cycle
module fp_div_mant
  import fp_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [M+1:0]  a,
  input  logic [M+1:0]  b,
  output logic [QW-1:0] q,
  output logic          rem_nz,
  output logic          mant_done
);
  logic [M+2:0] r_q, r_d;
  logic [QW-1:0] q_q;
  logic [4:0] cnt_q;
  logic run_q;
  logic [M+3:0] diff;
  logic ge;
  // After a successful subtract the remainder is below b, so the left shift never loses a set bit
  always_comb begin
    diff = {1'b0, r_q} - {2'b0, b};
    ge = !diff[M+3];
    r_d = (ge ? diff[M+2:0] : r_q) << 1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      r_q <= {1'b0, a};
      q_q <= '0;
      cnt_q <= 5'(QW - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      r_q <= r_d;
      q_q <= {q_q[QW-2:0], ge};
      cnt_q <= cnt_q - 5'd1;
      run_q <= cnt_q != 5'd0;
    end
  assign q = q_q;
  assign rem_nz = |r_q;
  assign mant_done = run_q && cnt_q == 5'd0;
endmodule

// File: rtl/fp_div.sv
// fp_div: iterative IEEE-754 single-precision divider, out = in1 / in2
//   clk, rst        : clock, asynchronous active-low reset
//   act             : start request, sampled only in IDLE
//   in1, in2        : dividend, divisor
//   round_m         : rounding mode (RNE, RZ, RD, RU, RNA)
//   out             : quotient, updated only when leaving FIN
//   ov, un, dz, inv : overflow, underflow, divide-by-zero, invalid
//   inexact         : rounded result differs from exact quotient
//   done            : result valid, held until the next accepted act
//   busy            : high in every state except IDLE
module fp_div
  import fp_div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         ov,
  output logic         un,
  output logic         dz,
  output logic         inv,
  output logic         inexact,
  output logic         done,
  output logic         busy
);
  fpd_state_t state_q, state_d;
  logic [W-1:0] a_q, b_q, res_q, res_d, out_q, spec_res, inf_s, zero_s;
  logic [2:0] rm_q;
  logic [9:0] ex_q, ex_d, exn, exf;
  logic [4:0] fl_q, fl_d, ofl_q, spec_fl;
  logic done_q, start, mant_done, rem_nz;
  logic [QW-1:0] q;
  logic [7:0] e1, e2;
  logic s, z1, z2, i1, i2, n1, n2, inv_c, nan_c, dz_c, special;
  logic hi, g, t, nx, inc, ovf, unf;
  logic [M:0] frac;
  logic [M+10:0] sum;
  fp_div_mant u_mant (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         ({1'b1, a_q[M:0]}),
    .b         ({1'b1, b_q[M:0]}),
    .q         (q),
    .rem_nz    (rem_nz),
    .mant_done (mant_done)
  );
  always_comb begin
    state_d = state_q;
    start = 1'b0;
    case (state_q)
      FPD_IDLE: if (act) state_d = FPD_LOAD;
      FPD_LOAD: begin
        state_d = special ? FPD_FIN : FPD_DIV;
        start = !special;
      end
      FPD_DIV: if (mant_done) state_d = FPD_RND;
      FPD_RND: state_d = FPD_FIN;
      default: state_d = FPD_IDLE;
    endcase
  end
  // Operand classification; exponent field 0 is zero (denormals flushed)
  always_comb begin
    e1 = a_q[E:M+1];
    e2 = b_q[E:M+1];
    s = a_q[W-1] ^ b_q[W-1];
    inf_s = s ? FP_INFN : FP_INFP;
    zero_s = s ? FP_ZERON : FP_ZEROP;
    z1 = e1 == 8'd0;
    z2 = e2 == 8'd0;
    i1 = &e1 && a_q[M:0] == '0;
    i2 = &e2 && b_q[M:0] == '0;
    n1 = &e1 && a_q[M:0] != '0;
    n2 = &e2 && b_q[M:0] != '0;
    inv_c = (n1 && !a_q[M]) || (n2 && !b_q[M]) || (z1 && z2) || (i1 && i2);
    nan_c = inv_c || n1 || n2;
    dz_c = !nan_c && z2 && !i1;
    special = z1 || z2 || i1 || i2 || n1 || n2;
    spec_res = nan_c ? FP_NANQ : (z2 || i1) ? inf_s : zero_s;
    spec_fl = {2'b00, dz_c, inv_c, 1'b0};
    ex_d = {2'b00, e1} - {2'b00, e2} + BIAS;
  end
  // Normalise, round and range-check; the rounding increment ripples from fraction into exponent
  always_comb begin
    hi = q[QW-1];
    frac = hi ? q[QW-2:2] : q[QW-3:1];
    g = hi ? q[1] : q[0];
    t = (hi && q[0]) || rem_nz;
    nx = g || t;
    exn = hi ? ex_q : ex_q - 10'd1;
    inc = rm_q == RNE ? g && (t || frac[0]) :
          rm_q == RNA ? g :
          rm_q == RU  ? nx && !s :
          rm_q == RD  ? nx && s :
          rm_q == RZ  ? 1'b0 : 1'b0;
    sum = {exn, frac} + (M+11)'(inc);
    exf = sum[M+10:M+1];
    ovf = !exf[9] && exf > 10'd254;
    unf = exf[9] || exf == 10'd0;
    res_d = state_q == FPD_LOAD ? spec_res :
            state_q == FPD_RND  ? (ovf ? inf_s : unf ? zero_s : {s, sum[W-2:0]}) : res_q;
    fl_d = state_q == FPD_LOAD ? spec_fl :
           state_q == FPD_RND  ? {ovf, unf, 2'b00, nx || ovf || unf} : fl_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= FPD_IDLE;
      a_q <= '0;
      b_q <= '0;
      rm_q <= '0;
      ex_q <= '0;
      res_q <= '0;
      fl_q <= '0;
      out_q <= '0;
      ofl_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      fl_q <= fl_d;
      if (state_q == FPD_IDLE && act) begin
        a_q <= in1;
        b_q <= in2;
        rm_q <= round_m;
        done_q <= 1'b0;
      end
      if (state_q == FPD_LOAD) ex_q <= ex_d;
      if (state_q == FPD_FIN) begin
        out_q <= res_q;
        ofl_q <= fl_q;
        done_q <= 1'b1;
      end
    end
  assign out = out_q;
  assign {ov, un, dz, inv, inexact} = ofl_q;
  assign done = done_q;
  assign busy = state_q != FPD_IDLE;
endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: scoreboard bench for fp_div with directed corner cases and random operands
module tb_fp_div;
  import fp_div_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic act = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic [2:0] round_m = '0;
  logic [31:0] out;
  logic ov, un, dz, inv, inexact, done, busy;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    int          acyc;
  } exp_t;
  exp_t sbq[$];
  int cmp = 0, errs = 0, cyc = 0;
  logic done_p = 1'b0;
  fp_div dut (
    .clk(clk), .rst(rst), .act(act), .in1(in1), .in2(in2), .round_m(round_m),
    .out(out), .ov(ov), .un(un), .dz(dz), .inv(inv), .inexact(inexact),
    .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    cmp++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", n, got, want, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1 && done_p !== 1'b1) begin
      if (sbq.size() == 0) begin
        cmp++;
        errs++;
        $display("FAIL unexpected_result got=%h expected=none", out);
      end else begin
        e = sbq.pop_front();
        chk("out", out, e.res);
        chk("flags{ov,un,dz,inv,nx}", 32'({ov, un, dz, inv, inexact}), 32'(e.fl));
        chk("latency", 32'(cyc - e.acyc), 32'(e.lat));
      end
    end
    done_p = done;
  end
  function automatic exp_t mk(input logic [31:0] res, input logic [4:0] fl, input int lat);
    exp_t e;
    e.res = res;
    e.fl = fl;
    e.lat = lat;
    e.acyc = 0;
    return e;
  endfunction
  // Reference: exact integer quotient with 25 fraction bits plus sticky, then IEEE rounding
  function automatic exp_t ref_div(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    exp_t r;
    logic s, z1, z2, i1, i2, n1, n2, g, st, up;
    int e1, e2, ex, ev;
    longint unsigned num, den, qt;
    longint v;
    logic [22:0] frac;
    s = x[31] ^ y[31];
    e1 = int'(x[30:23]);
    e2 = int'(y[30:23]);
    z1 = e1 == 0;
    z2 = e2 == 0;
    i1 = e1 == 255 && x[22:0] == 0;
    i2 = e2 == 255 && y[22:0] == 0;
    n1 = e1 == 255 && x[22:0] != 0;
    n2 = e2 == 255 && y[22:0] != 0;
    r = mk(32'h0, 5'b0, 2);
    if ((n1 && !x[22]) || (n2 && !y[22]) || (z1 && z2) || (i1 && i2)) begin
      r.res = 32'h7FC00000;
      r.fl = 5'b00010;
    end else if (n1 || n2) r.res = 32'h7FC00000;
    else if (z2 && !i1) begin
      r.res = {s, 31'h7F800000};
      r.fl = 5'b00100;
    end else if (i1) r.res = {s, 31'h7F800000};
    else if (z1 || i2) r.res = {s, 31'h0};
    else begin
      r.lat = 29;
      num = {40'd0, 1'b1, x[22:0]} << 25;
      den = {40'd0, 1'b1, y[22:0]};
      qt = num / den;
      st = (num % den) != 0;
      ex = e1 - e2 + 127;
      if (qt >= (64'd1 << 25)) begin
        g = qt[1];
        st = st | qt[0];
        frac = qt[24:2];
      end else begin
        g = qt[0];
        frac = qt[23:1];
        ex = ex - 1;
      end
      case (rm)
        RNE: up = g && (st || frac[0]);
        RNA: up = g;
        RU: up = (g || st) && !s;
        RD: up = (g || st) && s;
        default: up = 1'b0;
      endcase
      v = longint'(ex) * 64'sd8388608 + longint'({41'd0, frac}) + longint'({63'd0, up});
      ev = int'(v >>> 23);
      if (ev > 254) begin
        r.res = {s, 31'h7F800000};
        r.fl = 5'b10001;
      end else if (ev < 1) begin
        r.res = {s, 31'h0};
        r.fl = 5'b01001;
      end else begin
        r.res = {s, ev[7:0], v[22:0]};
        r.fl = {4'b0, g || st};
      end
    end
    return r;
  endfunction
  function automatic logic [31:0] rnd_op();
    int k;
    logic s;
    logic [22:0] f;
    logic [7:0] e;
    k = $urandom_range(0, 19);
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    if ($urandom_range(0, 7) == 0) f = 23'd0;
    e = 8'($urandom_range(100, 160));
    if (k == 0) return {s, 31'h0};
    if (k == 1) return {s, 31'h7F800000};
    if (k == 2) return {s, 8'hFF, 1'b1, f[21:0]};
    if (k == 3) return {s, 8'hFF, 1'b0, f[21:0] | 22'd1};
    if (k <= 7) e = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 20)) : 8'($urandom_range(235, 254));
    return {s, e, f};
  endfunction
  task automatic wait_empty();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      cmp++;
      errs++;
      $display("FAIL timeout got=no_done expected=done_within_40_cycles");
      sbq.delete();
    end
  endtask
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm, input exp_t e);
    @(negedge clk);
    e.acyc = cyc + 1;
    sbq.push_back(e);
    in1 = x;
    in2 = y;
    round_m = rm;
    act = 1'b1;
    @(negedge clk);
    act = 1'b0;
    chk("busy", 32'(busy), 32'd1);
    wait_empty();
    repeat (3) @(negedge clk);
    chk("done_held", 32'(done), 32'd1);
    chk("out_held", out, e.res);
  endtask
  initial begin
    logic [31:0] x, y;
    logic [2:0] rm;
    repeat (2) @(negedge clk);
    chk("rst_out", out, 32'h0);
    chk("rst_flags", 32'({ov, un, dz, inv, inexact}), 32'h0);
    chk("rst_done_busy", 32'({done, busy}), 32'h0);
    rst = 1'b1;
    issue(32'h40C00000, 32'h40000000, RNE, mk(32'h40400000, 5'b00000, 29));
    issue(32'h3F800000, 32'h40400000, RNE, mk(32'h3EAAAAAB, 5'b00001, 29));
    issue(32'h3F800000, 32'h40400000, RZ, mk(32'h3EAAAAAA, 5'b00001, 29));
    issue(32'h3F800000, 32'h40400000, RU, mk(32'h3EAAAAAB, 5'b00001, 29));
    issue(32'h3F800000, 32'h40400000, RD, mk(32'h3EAAAAAA, 5'b00001, 29));
    issue(32'hBF800000, 32'h40400000, RD, mk(32'hBEAAAAAB, 5'b00001, 29));
    issue(32'hC0C00000, 32'h40000000, RD, mk(32'hC0400000, 5'b00000, 29));
    issue(32'h3F800000, 32'h00000000, RNE, mk(32'h7F800000, 5'b00100, 2));
    issue(32'hBF800000, 32'h00000000, RNE, mk(32'hFF800000, 5'b00100, 2));
    issue(32'h00000000, 32'h00000000, RNE, mk(32'h7FC00000, 5'b00010, 2));
    issue(32'h7F800000, 32'h7F800000, RNE, mk(32'h7FC00000, 5'b00010, 2));
    issue(32'h7F000000, 32'h3E800000, RNE, mk(32'h7F800000, 5'b10001, 29));
    issue(32'h00800000, 32'h7F000000, RNE, mk(32'h00000000, 5'b01001, 29));
    // act during a running divide must be ignored
    @(negedge clk);
    sbq.push_back(mk(32'h40400000, 5'b00000, 29));
    sbq[0].acyc = cyc + 1;
    in1 = 32'h40C00000;
    in2 = 32'h40000000;
    round_m = RNE;
    act = 1'b1;
    @(negedge clk);
    act = 1'b0;
    repeat (4) @(negedge clk);
    in1 = 32'h3F800000;
    in2 = 32'h40400000;
    act = 1'b1;
    @(negedge clk);
    act = 1'b0;
    wait_empty();
    repeat (35) @(negedge clk);
    chk("ignored_act_out", out, 32'h40400000);
    // reset in the middle of a divide aborts it
    in1 = 32'h3F800000;
    in2 = 32'h40400000;
    act = 1'b1;
    @(negedge clk);
    act = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out", out, 32'h0);
    chk("midrst_flags", 32'({ov, un, dz, inv, inexact}), 32'h0);
    chk("midrst_done_busy", 32'({done, busy}), 32'h0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_result", 32'(done), 32'h0);
    issue(32'h3F800000, 32'h40400000, RZ, mk(32'h3EAAAAAA, 5'b00001, 29));
    for (int n = 0; n < 200; n++) begin
      x = rnd_op();
      y = rnd_op();
      rm = 3'($urandom_range(0, 4));
      issue(x, y, rm, ref_div(x, y, rm));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
